cmp_operand_loader: RTL and testbench
=====================================

# cmp_operand_loader

Serial front-end and result-capture stage for the 4-bit transistor-level magnitude comparator. Assembles two operands from LSB-first serial streams and drives them as stable parallel words onto the comparator's a0..a3/b0..b3 inputs. Waits a programmable settle interval so the delayed CMOS ripple chain can resolve, then registers the comparator's g3/e3 outputs as a one-cycle result. Keeps saturating tallies of greater/equal/less outcomes.

## Interface
- WIDTH, 4: operand width; must match the comparator (bit 0 = LSB, feeds ripple stage 0).
- SETTLE, 3: clock cycles between operand update and result sampling; legal range 1..15.
- CNTW, 8: tally counter width.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- sin_a  in  1  serial bit of operand A, LSB first.
- sin_b  in  1  serial bit of operand B, LSB first.
- sin_valid  in  1  sin_a/sin_b carry a bit this cycle.
- clr  in  1  synchronous clear of tally counters.
- a  out  WIDTH  operand A to comparator (a[0]→a0 … a[3]→a3).
- b  out  WIDTH  operand B to comparator.
- g_in  in  1  comparator g3 (A>B).
- e_in  in  1  comparator e3 (A==B).
- busy  out  1  high while settling; serial bits ignored.
- res_valid  out  1  one-cycle strobe, result fields valid.
- res_gt, res_eq, res_lt  out  1 each  registered outcome; held until next capture.
- res_err  out  1  g_in and e_in both high at capture.
- gt_cnt, eq_cnt, lt_cnt  out  CNTW each  saturating tallies.

## Operation
- States: IDLE, SHIFT, SETTLE. Bit counter bcnt (0..WIDTH-1), settle counter scnt (0..SETTLE-1).
- IDLE/SHIFT with sin_valid=1: shift registers sa <= {sin_a, sa[WIDTH-1:1]}, sb likewise; bcnt++; IDLE→SHIFT on first bit.
- On the bit with bcnt==WIDTH-1: a <= {sin_a, sa[WIDTH-1:1]}, b likewise (full word, first received bit at [0]); bcnt <= 0; scnt <= 0; →SETTLE.
- a/b change only on word completion; stable for the whole settle window and until the next word completes.
- SETTLE: busy=1; sin_valid ignored (not buffered, not counted). scnt++ each cycle; on the cycle with scnt==SETTLE-1: capture →IDLE.
- Capture: res_gt<=g_in; res_eq<=e_in; res_lt<=~g_in&~e_in; res_err<=g_in&e_in; res_valid<=1 for exactly one cycle.
- Tallies: at capture with res_err=0, increment the matching counter; saturate at 2^CNTW-1. Error captures increment none.
- clr: counters <= 0 next edge; clr coinciding with capture wins (capture not counted).
- sin_valid deasserted mid-word: SHIFT holds bcnt and partial word indefinitely.

## Timing
- Reset (rstn low, async): state IDLE, bcnt=scnt=0, sa=sb=a=b=0, busy=0, res_valid=res_gt=res_eq=res_lt=res_err=0, all counts 0. Reset mid-word or mid-settle discards the operation; no res_valid.
- Last bit accepted at edge E: a/b update at E, busy high from E to E+SETTLE, g_in/e_in sampled at edge E+SETTLE, res_valid high for the cycle after E+SETTLE.
- Minimum word period: WIDTH+SETTLE cycles. The first bit of the next word may be accepted in the cycle res_valid is high (state already IDLE).
- SETTLE×clock period must exceed comparator worst-case ripple delay; 3 cycles at 10 ns covers the four-stage chain.

## Test plan
- Reset: hold rstn=0 with random inputs → all outputs 0; release, no res_valid without input.
- A=0101, B=0011 shifted LSB first (a:1,0,1,0; b:1,1,0,0) → a=0101, b=0011 at edge E; res_valid at E+SETTLE+1 with res_gt=1, gt_cnt=1.
- A=B=1010 → res_eq=1, res_lt=0; A=0010, B=1000 → res_lt=1; tallies 1/1/1.
- Stream 4 extra bits with sin_valid=1 during SETTLE → ignored, a/b unchanged, next word requires full 4 new bits.
- Force g_in=e_in=1 at capture → res_err=1, no tally change; 256 GT words with CNTW=8 → gt_cnt stays 255; clr coincident with capture → gt_cnt=0.
- rstn pulse after 2 of 4 bits, then full word → result reflects only post-reset word.

Source files
------------

// File: rtl/cmp_operand_loader.sv
// Serial operand loader and result capture for the 4-bit ripple magnitude comparator.
// Assembles LSB-first words, holds them through a settle window, then samples g3/e3.
module cmp_operand_loader #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 3,
    parameter int CNTW   = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sin_a,
    input  logic             sin_b,
    input  logic             sin_valid,
    input  logic             clr,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    input  logic             g_in,
    input  logic             e_in,
    output logic             busy,
    output logic             res_valid,
    output logic             res_gt,
    output logic             res_eq,
    output logic             res_lt,
    output logic             res_err,
    output logic [CNTW-1:0]  gt_cnt,
    output logic [CNTW-1:0]  eq_cnt,
    output logic [CNTW-1:0]  lt_cnt
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_SETTLE
    } state_t;

    state_t            state;
    logic [BW-1:0]     bcnt;
    logic [3:0]        scnt;
    logic [WIDTH-2:0]  sh_a;
    logic [WIDTH-2:0]  sh_b;
    logic [WIDTH-1:0]  nxt_a;
    logic [WIDTH-1:0]  nxt_b;
    logic              last_bit;
    logic              capture;

    // Shift registers only keep the bits received so far; the incoming bit tops the word
    assign nxt_a    = {sin_a, sh_a};
    assign nxt_b    = {sin_b, sh_b};
    assign last_bit = (bcnt == BW'(WIDTH - 1));
    assign capture  = (state == S_SETTLE) && (scnt == 4'(SETTLE - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            bcnt      <= '0;
            scnt      <= '0;
            sh_a      <= '0;
            sh_b      <= '0;
            a         <= '0;
            b         <= '0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_gt    <= 1'b0;
            res_eq    <= 1'b0;
            res_lt    <= 1'b0;
            res_err   <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            unique case (state)
                S_IDLE, S_SHIFT: begin
                    if (sin_valid) begin
                        sh_a <= nxt_a[WIDTH-1:1];
                        sh_b <= nxt_b[WIDTH-1:1];
                        if (last_bit) begin
                            a     <= nxt_a;
                            b     <= nxt_b;
                            bcnt  <= '0;
                            scnt  <= '0;
                            busy  <= 1'b1;
                            state <= S_SETTLE;
                        end else begin
                            bcnt  <= bcnt + 1'b1;
                            state <= S_SHIFT;
                        end
                    end
                end
                S_SETTLE: begin
                    if (capture) begin
                        res_gt    <= g_in;
                        res_eq    <= e_in;
                        res_lt    <= ~g_in & ~e_in;
                        res_err   <= g_in & e_in;
                        res_valid <= 1'b1;
                        busy      <= 1'b0;
                        scnt      <= '0;
                        state     <= S_IDLE;
                    end else begin
                        scnt <= scnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Tallies saturate; clr overrides a coincident capture
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gt_cnt <= '0;
            eq_cnt <= '0;
            lt_cnt <= '0;
        end else if (clr) begin
            gt_cnt <= '0;
            eq_cnt <= '0;
            lt_cnt <= '0;
        end else if (capture && !(g_in && e_in)) begin
            if (g_in && gt_cnt != '1)
                gt_cnt <= gt_cnt + CNTW'(1);
            if (e_in && eq_cnt != '1)
                eq_cnt <= eq_cnt + CNTW'(1);
            if (!g_in && !e_in && lt_cnt != '1)
                lt_cnt <= lt_cnt + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_cmp_operand_loader.sv
// Directed bench for cmp_operand_loader: table of words plus settle,
// saturation, clear and reset corner sequences.
module tb_cmp_operand_loader;

    localparam int SETTLE = 3;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       sin_a = 1'b0;
    logic       sin_b = 1'b0;
    logic       sin_valid = 1'b0;
    logic       clr = 1'b0;
    logic       g_in = 1'b0;
    logic       e_in = 1'b0;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       res_valid;
    logic       res_gt;
    logic       res_eq;
    logic       res_lt;
    logic       res_err;
    logic [7:0] gt_cnt;
    logic [7:0] eq_cnt;
    logic [7:0] lt_cnt;

    cmp_operand_loader #(.WIDTH(4), .SETTLE(SETTLE), .CNTW(8)) dut (
        .clk(clk), .rstn(rstn), .sin_a(sin_a), .sin_b(sin_b),
        .sin_valid(sin_valid), .clr(clr), .a(a), .b(b),
        .g_in(g_in), .e_in(e_in), .busy(busy), .res_valid(res_valid),
        .res_gt(res_gt), .res_eq(res_eq), .res_lt(res_lt),
        .res_err(res_err), .gt_cnt(gt_cnt), .eq_cnt(eq_cnt),
        .lt_cnt(lt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic [3:0] va;
        logic [3:0] vb;
        logic       gi;
        logic       ei;
        logic [3:0] xflags;
    } vec_t;

    int   napplied = 0;
    int   nmis = 0;
    int   m_gt = 0;
    int   m_eq = 0;
    int   m_lt = 0;
    vec_t tv[8];

    function automatic int sat(input int x);
        return (x < 255) ? x + 1 : 255;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        napplied++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [3:0] va, input logic [3:0] vb);
        for (int i = 0; i < 4; i++) begin
            sin_a = va[i];
            sin_b = vb[i];
            sin_valid = 1'b1;
            tick();
        end
        sin_valid = 1'b0;
    endtask

    task automatic wait_result(input string nm, input bit junk);
        int n;
        n = 0;
        while (!res_valid && n < 20) begin
            if (junk) begin
                sin_valid = 1'b1;
                sin_a = ~sin_a;
                sin_b = sin_a;
            end
            tick();
            n++;
        end
        sin_valid = 1'b0;
        chk({nm, " latency"}, n, SETTLE);
    endtask

    task automatic model_count(input logic [3:0] fl);
        if (!fl[0]) begin
            if (fl[3]) m_gt = sat(m_gt);
            if (fl[2]) m_eq = sat(m_eq);
            if (fl[1]) m_lt = sat(m_lt);
        end
    endtask

    task automatic run_word(input vec_t v, input bit junk);
        g_in = v.gi;
        e_in = v.ei;
        send_word(v.va, v.vb);
        chk({v.nm, " a"}, a, v.va);
        chk({v.nm, " b"}, b, v.vb);
        chk({v.nm, " busy"}, busy, 1);
        wait_result(v.nm, junk);
        model_count(v.xflags);
        chk({v.nm, " flags"}, {res_gt, res_eq, res_lt, res_err}, v.xflags);
        chk({v.nm, " counts"}, {gt_cnt, eq_cnt, lt_cnt},
            {m_gt[7:0], m_eq[7:0], m_lt[7:0]});
        chk({v.nm, " busy off"}, busy, 0);
        chk({v.nm, " a held"}, a, v.va);
        tick();
        chk({v.nm, " strobe"}, res_valid, 0);
        chk({v.nm, " hold"}, {res_gt, res_eq, res_lt, res_err}, v.xflags);
    endtask

    initial begin
        tv[0] = '{"gt0101", 4'b0101, 4'b0011, 1'b1, 1'b0, 4'b1000};
        tv[1] = '{"eq1010", 4'b1010, 4'b1010, 1'b0, 1'b1, 4'b0100};
        tv[2] = '{"lt0010", 4'b0010, 4'b1000, 1'b0, 1'b0, 4'b0010};
        tv[3] = '{"gt1111", 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b1000};
        tv[4] = '{"eq0000", 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0100};
        tv[5] = '{"lt0111", 4'b0111, 4'b1000, 1'b0, 1'b0, 4'b0010};
        tv[6] = '{"err1100", 4'b1100, 4'b1100, 1'b1, 1'b1, 4'b1101};
        tv[7] = '{"lt0001", 4'b0001, 4'b1110, 1'b0, 1'b0, 4'b0010};

        for (int i = 0; i < 5; i++) begin
            sin_a = 1'($urandom);
            sin_b = 1'($urandom);
            sin_valid = 1'($urandom);
            g_in = 1'($urandom);
            e_in = 1'($urandom);
            tick();
            chk("reset outs", {a, b, busy, res_valid, res_gt, res_eq, res_lt,
                res_err}, 0);
        end
        chk("reset cnts", {gt_cnt, eq_cnt, lt_cnt}, 0);
        sin_valid = 1'b0;
        g_in = 1'b0;
        e_in = 1'b0;
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("idle quiet", {busy, res_valid}, 0);
        end

        for (int i = 0; i < 8; i++)
            run_word(tv[i], 1'b0);

        run_word('{"settle_junk", 4'b0110, 4'b0001, 1'b1, 1'b0, 4'b1000},
                 1'b1);
        run_word('{"post_junk", 4'b0011, 4'b0011, 1'b0, 1'b1, 4'b0100},
                 1'b0);

        for (int i = 0; i < 260; i++)
            run_word('{"sat", 4'b1001, 4'b0001, 1'b1, 1'b0, 4'b1000}, 1'b0);
        chk("gt saturated", gt_cnt, 255);

        g_in = 1'b1;
        e_in = 1'b0;
        send_word(4'b1000, 4'b0001);
        repeat (SETTLE - 1) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        m_gt = 0;
        m_eq = 0;
        m_lt = 0;
        chk("clr cap valid", {res_valid, res_gt}, 2'b11);
        chk("clr cap cnts", {gt_cnt, eq_cnt, lt_cnt}, 0);
        tick();

        for (int i = 0; i < 2; i++) begin
            sin_a = 1'b1;
            sin_b = 1'b0;
            sin_valid = 1'b1;
            tick();
        end
        sin_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("midword rst", {a, b, busy, res_valid, gt_cnt}, 0);
        tick();
        rstn = 1'b1;
        tick();
        run_word('{"post_rst", 4'b1001, 4'b0110, 1'b1, 1'b0, 4'b1000}, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", napplied, nmis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
